// File: rtl/dmem_unit.sv
// ---------------------------------------------------------------------------
// dmem_unit - data memory sitting directly after the CPU's MEM stage.
//
// The block holds a word-organised RAM with byte-enable stores and sub-word
// loads (sign or zero extended). It also decodes a 16-byte memory-mapped I/O
// window holding an LED register, a free-running cycle counter, the board
// switches and a sticky misalignment-fault address register.
//
// Ports
//   clk       in   1   rising-edge clock
//   reset     in   1   asynchronous, active-low reset
//   mem_w     in   1   store strobe for the current cycle
//   load_chk  in   1   MEM-stage instruction is a load (arms misaligned-load faults)
//   addr      in  32   byte address
//   wdata     in  32   right-aligned store data
//   dm_ctrl   in   3   000 word, 001 half, 010 half-unsigned, 011 byte,
//                      100 byte-unsigned, 101..111 word
//   rdata     out 32   combinational load data
//   sw_in     in  16   board switches
//   led_out   out 16   low half of the LED register
//   fault     out  1   sticky misalignment flag
// ---------------------------------------------------------------------------
module dmem_unit #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] IO_BASE     = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_w,
  input  logic        load_chk,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  dm_ctrl,
  output logic [31:0] rdata,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out,
  output logic        fault
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    SZ_WORD,
    SZ_HALF,
    SZ_BYTE
  } size_e;

  // I/O register offsets, addressed by addr[3:2].
  localparam logic [1:0] IO_LED   = 2'd0;
  localparam logic [1:0] IO_CYCLE = 2'd1;
  localparam logic [1:0] IO_SW    = 2'd2;
  localparam logic [1:0] IO_FADDR = 2'd3;

  // -------------------------------------------------------------------------
  // Access decode
  // -------------------------------------------------------------------------
  size_e      size;
  logic       is_unsigned;
  logic       is_io;
  logic       misaligned;
  logic       store_ok;
  logic       fault_evt;
  logic       io_we;
  logic       ram_we;
  logic [AW-1:0] word_idx;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    size        = SZ_WORD;
    is_unsigned = 1'b0;
    unique case (dm_ctrl)
      3'b001:  size = SZ_HALF;
      3'b010:  begin size = SZ_HALF; is_unsigned = 1'b1; end
      3'b011:  size = SZ_BYTE;
      3'b100:  begin size = SZ_BYTE; is_unsigned = 1'b1; end
      default: size = SZ_WORD;
    endcase
  end

  assign is_io      = (addr[31:4] == IO_BASE[31:4]);
  assign misaligned = ((size == SZ_WORD) && (addr[1:0] != 2'b00)) ||
                      ((size == SZ_HALF) && addr[0]);
  assign store_ok   = mem_w && !misaligned;
  // The CPU drives its ALU result onto addr every cycle, so a misaligned
  // address without mem_w only counts when the instruction really is a load.
  assign fault_evt  = misaligned && (mem_w || load_chk);
  assign io_we      = store_ok && is_io;
  // Gating with reset drops a store that coincides with reset assertion.
  assign ram_we     = store_ok && !is_io && reset;
  assign word_idx   = addr[AW+1:2];

  // -------------------------------------------------------------------------
  // RAM: byte-enable write, asynchronous read
  // -------------------------------------------------------------------------
  logic [31:0] mem [DEPTH_WORDS];
  logic [3:0]  byte_en;
  logic [31:0] wlanes;

  always_comb begin
    byte_en = 4'b0000;
    wlanes  = wdata;
    unique case (size)
      SZ_BYTE: begin
        byte_en = 4'b0001 << addr[1:0];
        wlanes  = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        byte_en = addr[1] ? 4'b1100 : 4'b0011;
        wlanes  = {2{wdata[15:0]}};
      end
      default: byte_en = 4'b1111;
    endcase
  end

  // NOTE: the array has no reset branch; clearing a RAM on reset is neither
  // required nor implementable as a block RAM, so contents start undefined.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wlanes[8*b +: 8];
      end
    end
  end

  // -------------------------------------------------------------------------
  // I/O registers
  // -------------------------------------------------------------------------
  logic [31:0] led_reg;
  logic [31:0] cycle_cnt;
  logic [31:0] fault_addr;
  logic        fault_clr;

  assign fault_clr = io_we && (addr[3:2] == IO_FADDR);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_reg    <= '0;
      cycle_cnt  <= '0;
      fault      <= 1'b0;
      fault_addr <= '0;
    end else begin
      if (io_we && (addr[3:2] == IO_LED)) led_reg <= wdata;

      if (io_we && (addr[3:2] == IO_CYCLE)) cycle_cnt <= wdata;
      else                                  cycle_cnt <= cycle_cnt + 32'd1;

      // The first fault address sticks until software clears it; a new fault
      // arriving together with a clear takes priority over the clear.
      if (fault_evt && (!fault || fault_clr)) begin
        fault      <= 1'b1;
        fault_addr <= addr;
      end else if (fault_clr) begin
        fault      <= 1'b0;
        fault_addr <= '0;
      end
    end
  end

  assign led_out = led_reg[15:0];

  // -------------------------------------------------------------------------
  // Load path
  // -------------------------------------------------------------------------
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ram_load;
  logic [31:0] io_load;

  assign rd_word = mem[word_idx];
  assign rd_byte = rd_word[8*addr[1:0] +: 8];
  assign rd_half = addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ram_load = rd_word;
    unique case (size)
      SZ_BYTE: ram_load = is_unsigned ? {24'b0, rd_byte}
                                      : {{24{rd_byte[7]}}, rd_byte};
      SZ_HALF: ram_load = is_unsigned ? {16'b0, rd_half}
                                      : {{16{rd_half[15]}}, rd_half};
      default: ram_load = rd_word;
    endcase
  end

  always_comb begin
    io_load = '0;
    unique case (addr[3:2])
      IO_LED:   io_load = led_reg;
      IO_CYCLE: io_load = cycle_cnt;
      IO_SW:    io_load = {16'b0, sw_in};
      IO_FADDR: io_load = fault_addr;
      default:  io_load = '0;
    endcase
  end

  assign rdata = misaligned ? 32'b0 : (is_io ? io_load : ram_load);

endmodule

// File: tb/tb_dmem_unit.sv
// ---------------------------------------------------------------------------
// tb_dmem_unit - self-checking bench for dmem_unit.
// A byte-array reference model with plain-arithmetic I/O registers predicts
// every output; directed steps cover the key scenarios, followed by a
// randomized section over a pre-initialised RAM region and the I/O window.
// ---------------------------------------------------------------------------
module tb_dmem_unit;

  localparam int unsigned DEPTH   = 1024;
  localparam logic [31:0] IO_BASE = 32'hFFFF_0000;
  localparam int unsigned NBYTES  = 4 * DEPTH;

  logic        clk;
  logic        reset;
  logic        mem_w;
  logic        load_chk;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  dm_ctrl;
  logic [31:0] rdata;
  logic [15:0] sw_in;
  logic [15:0] led_out;
  logic        fault;

  dmem_unit #(.DEPTH_WORDS(DEPTH), .IO_BASE(IO_BASE)) dut (
    .clk     (clk),
    .reset   (reset),
    .mem_w   (mem_w),
    .load_chk(load_chk),
    .addr    (addr),
    .wdata   (wdata),
    .dm_ctrl (dm_ctrl),
    .rdata   (rdata),
    .sw_in   (sw_in),
    .led_out (led_out),
    .fault   (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [7:0]  mb [NBYTES];
  logic [31:0] m_led;
  logic [31:0] m_cyc;
  bit          m_fault;
  logic [31:0] m_fa;
  logic [31:0] last_rd;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int acc_bytes(input logic [2:0] c);
    case (c)
      3'd1, 3'd2: return 2;
      3'd3, 3'd4: return 1;
      default:    return 4;
    endcase
  endfunction

  function automatic bit in_io(input logic [31:0] a);
    return (a[31:4] == IO_BASE[31:4]);
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a, input logic [2:0] c);
    int          sz = acc_bytes(c);
    bit          uns = (c == 3'd2) || (c == 3'd4);
    int unsigned i;
    logic [15:0] h;
    if ((a % sz) != 0) return 32'd0;
    if (in_io(a)) begin
      case (a[3:2])
        2'd0:    return m_led;
        2'd1:    return m_cyc;
        2'd2:    return {16'd0, sw_in};
        default: return m_fa;
      endcase
    end
    i = a % NBYTES;
    if (sz == 4) return {mb[i+3], mb[i+2], mb[i+1], mb[i]};
    if (sz == 2) begin
      h = {mb[i+1], mb[i]};
      return uns ? {16'd0, h} : {{16{h[15]}}, h};
    end
    return uns ? {24'd0, mb[i]} : {{24{mb[i][7]}}, mb[i]};
  endfunction

  // Advance the model by one clock edge with the given bus inputs.
  task automatic model_edge(input bit mw, input logic [31:0] a, input logic [31:0] wd,
                            input logic [2:0] c, input bit lchk);
    int sz  = acc_bytes(c);
    bit mis = (a % sz) != 0;
    bit wr  = mw && !mis;
    bit evt = mis && (mw || lchk);
    bit clr = wr && in_io(a) && (a[3:2] == 2'd3);
    if (wr && !in_io(a)) begin
      for (int k = 0; k < sz; k++) mb[(a % NBYTES) + k] = wd[8*k +: 8];
    end
    if (wr && in_io(a) && a[3:2] == 2'd1) m_cyc = wd;
    else                                  m_cyc = m_cyc + 1;
    if (wr && in_io(a) && a[3:2] == 2'd0) m_led = wd;
    if (evt && (!m_fault || clr)) begin
      m_fault = 1'b1;
      m_fa    = a;
    end else if (clr) begin
      m_fault = 1'b0;
      m_fa    = 32'd0;
    end
  endtask

  task automatic model_reset();
    m_led   = 32'd0;
    m_cyc   = 32'd0;
    m_fault = 1'b0;
    m_fa    = 32'd0;
  endtask

  // One bus cycle: called just after a rising edge, drives inputs, checks the
  // outputs at the falling edge, then advances across the next rising edge.
  task automatic do_cycle(input string tag, input bit mw, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] c, input bit lchk);
    mem_w    = mw;
    addr     = a;
    wdata    = wd;
    dm_ctrl  = c;
    load_chk = lchk;
    @(negedge clk);
    last_rd = rdata;
    if (!mw) check32({tag, ".rdata"}, rdata, exp_rdata(a, c));
    check32({tag, ".led"}, {16'd0, led_out}, {16'd0, m_led[15:0]});
    check32({tag, ".fault"}, {31'd0, fault}, {31'd0, m_fault});
    @(posedge clk);
    model_edge(mw, a, wd, c, lchk);
    #1;
  endtask

  localparam logic [2:0] W = 3'd0, H = 3'd1, HU = 3'd2, B = 3'd3, BU = 3'd4;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; mem_w = 1'b0; load_chk = 1'b0; addr = '0; wdata = '0;
    dm_ctrl = '0; sw_in = 16'hA5A5;
    model_reset();

    // Reset state.
    repeat (2) @(negedge clk);
    check32("rst.led", {16'd0, led_out}, 32'd0);
    check32("rst.fault", {31'd0, fault}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Switches and cycle counter right after reset.
    do_cycle("sw", 0, IO_BASE + 8, 0, W, 1);
    check32("sw.plan", last_rd, 32'h0000_A5A5);
    do_cycle("idle", 0, 32'h0, 0, W, 0);
    do_cycle("cyc2", 0, IO_BASE + 4, 0, W, 1);
    check32("cyc2.plan", last_rd, 32'd2);
    do_cycle("faddr0", 0, IO_BASE + 12, 0, W, 1);
    check32("faddr0.plan", last_rd, 32'd0);

    // Byte-enable stores.
    do_cycle("sw10", 1, 32'h10, 32'h1122_3344, W, 0);
    do_cycle("sb11", 1, 32'h11, 32'h0000_00AA, B, 0);
    do_cycle("sh12", 1, 32'h12, 32'h0000_BEEF, H, 0);
    do_cycle("lw10", 0, 32'h10, 0, W, 1);
    check32("lw10.plan", last_rd, 32'hBEEF_AA44);

    // Sign / zero extension.
    do_cycle("sw20", 1, 32'h20, 32'h80F0_7F81, W, 0);
    do_cycle("lb20", 0, 32'h20, 0, B, 1);
    check32("lb20.plan", last_rd, 32'hFFFF_FF81);
    do_cycle("lbu20", 0, 32'h20, 0, BU, 1);
    check32("lbu20.plan", last_rd, 32'h0000_0081);
    do_cycle("lh22", 0, 32'h22, 0, H, 1);
    check32("lh22.plan", last_rd, 32'hFFFF_80F0);
    do_cycle("lhu22", 0, 32'h22, 0, HU, 1);
    check32("lhu22.plan", last_rd, 32'h0000_80F0);
    do_cycle("lb21", 0, 32'h21, 0, B, 1);
    do_cycle("ctrl5", 0, 32'h20, 0, 3'd5, 1);
    check32("ctrl5.plan", last_rd, 32'h80F0_7F81);

    // Address aliasing above the RAM size.
    do_cycle("alias_st", 1, 32'h10 + NBYTES, 32'h0BAD_F00D, W, 0);
    do_cycle("alias_ld", 0, 32'h10, 0, W, 1);
    check32("alias.plan", last_rd, 32'h0BAD_F00D);

    // Misalignment faults.
    do_cycle("sw30", 1, 32'h30, 32'hCAFE_0001, W, 0);
    do_cycle("mis_sw32", 1, 32'h32, 32'hDEAD_DEAD, W, 0);
    do_cycle("lw30", 0, 32'h30, 0, W, 1);
    check32("lw30.plan", last_rd, 32'hCAFE_0001);
    check32("mis.fault", {31'd0, fault}, 32'd1);
    do_cycle("fa32", 0, IO_BASE + 12, 0, W, 1);
    check32("fa32.plan", last_rd, 32'h32);
    do_cycle("mis_lh35", 0, 32'h35, 0, H, 1);
    check32("mis_lh35.plan", last_rd, 32'd0);
    do_cycle("fa_keep", 0, IO_BASE + 12, 0, W, 1);
    check32("fa_keep.plan", last_rd, 32'h32);

    // Clear, re-fault at 0x41, clean clear; unarmed misaligned load ignored.
    do_cycle("clr1", 1, IO_BASE + 12, 32'h1234, W, 0);
    do_cycle("mis_sh41", 1, 32'h41, 32'h5555, H, 0);
    do_cycle("fa41", 0, IO_BASE + 12, 0, W, 1);
    check32("fa41.plan", last_rd, 32'h41);
    check32("fa41.fault", {31'd0, fault}, 32'd1);
    do_cycle("clr2", 1, IO_BASE + 12, 32'h0, W, 0);
    do_cycle("nochk43", 0, 32'h43, 0, W, 0);
    check32("nochk43.rd", last_rd, 32'd0);
    check32("clr2.fault", {31'd0, fault}, 32'd0);
    do_cycle("fa_clr", 0, IO_BASE + 12, 0, W, 1);
    check32("fa_clr.plan", last_rd, 32'd0);

    // Cycle counter wrap after a load.
    do_cycle("cyc_wr", 1, IO_BASE + 4, 32'hFFFF_FFFE, W, 0);
    do_cycle("cyc_a", 0, IO_BASE + 4, 0, W, 1);
    do_cycle("cyc_b", 0, IO_BASE + 4, 0, W, 1);
    check32("cyc_b.plan", last_rd, 32'hFFFF_FFFF);
    do_cycle("cyc_c", 0, IO_BASE + 4, 0, W, 1);
    check32("cyc_c.plan", last_rd, 32'd0);
    do_cycle("cyc_d", 0, IO_BASE + 4, 0, W, 1);
    check32("cyc_d.plan", last_rd, 32'd1);

    // LED register; SW is read-only; sub-word I/O acts as a word access.
    do_cycle("led_wr", 1, IO_BASE, 32'h1234_5678, W, 0);
    do_cycle("led_rd", 0, IO_BASE, 0, W, 1);
    check32("led.plan", {16'd0, led_out}, 32'h0000_5678);
    do_cycle("sw_wr", 1, IO_BASE + 8, 32'hFFFF_FFFF, W, 0);
    do_cycle("sw_rd", 0, IO_BASE + 8, 0, W, 1);
    do_cycle("led_sb", 1, IO_BASE + 1, 32'h0000_9ABC, B, 0);
    do_cycle("led_lb", 0, IO_BASE + 3, 0, B, 1);
    check32("led_lb.plan", last_rd, 32'h0000_9ABC);

    // Reset asserted in the middle of a store: the store is lost.
    do_cycle("mis_pre", 1, 32'h22, 0, W, 0);
    mem_w = 1'b1; addr = 32'h20; wdata = 32'h5555_5555; dm_ctrl = W; load_chk = 1'b0;
    #2 reset = 1'b0;
    model_reset();
    @(negedge clk);
    check32("rst2.led", {16'd0, led_out}, 32'd0);
    check32("rst2.fault", {31'd0, fault}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    do_cycle("rst2_lw", 0, 32'h20, 0, W, 1);
    check32("rst2_lw.plan", last_rd, 32'h80F0_7F81);

    // Randomized traffic over an initialised RAM region and the I/O window.
    for (int k = 0; k < 16; k++) do_cycle("rinit", 1, 32'h100 + 4 * k, $urandom, W, 0);
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      int          sel = $urandom_range(0, 9);
      if (sel < 6)      a = 32'h100 + $urandom_range(0, 63);
      else if (sel < 8) a = 32'h100 + $urandom_range(0, 63) + NBYTES * $urandom_range(1, 3);
      else              a = IO_BASE + $urandom_range(0, 15);
      sw_in = 16'($urandom);
      do_cycle("rand", 1'($urandom_range(0, 2) == 0), a, $urandom,
               3'($urandom_range(0, 7)), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
